// File: rtl/resp_demux_4.sv
// Registered 1-to-4 response demux; each lane owns a one-entry holding
// register so a stalled consumer only back-pressures beats aimed at it.
module resp_demux_4 #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [1:0]        select_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic [DATA_W-1:0] data1_o,
  output logic [DATA_W-1:0] data2_o,
  output logic [DATA_W-1:0] data3_o,
  output logic [DATA_W-1:0] data4_o,
  output logic              valid1_o,
  output logic              valid2_o,
  output logic              valid3_o,
  output logic              valid4_o,
  input  logic              ready1_i,
  input  logic              ready2_i,
  input  logic              ready3_i,
  input  logic              ready4_i,
  output logic [CNT_W-1:0]  beat_cnt_o
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } lane_st_t;

  lane_st_t          st_q  [4];
  lane_st_t          st_d  [4];
  logic [DATA_W-1:0] dat_q [4];
  logic [DATA_W-1:0] dat_d [4];
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [3:0]        rdy;
  logic [3:0]        sel_oh;
  logic [3:0]        acc;
  logic [3:0]        dlv;

  assign rdy = {ready4_i, ready3_i, ready2_i, ready1_i};

  always_comb begin
    sel_oh = 4'b0001 << select_i;
  end

  // Only the addressed lane can stall the producer.
  always_comb begin
    ready_o = 1'b0;
    unique case (1'b1)
      sel_oh[0]: ready_o = (st_q[0] == EMPTY) | rdy[0];
      sel_oh[1]: ready_o = (st_q[1] == EMPTY) | rdy[1];
      sel_oh[2]: ready_o = (st_q[2] == EMPTY) | rdy[2];
      sel_oh[3]: ready_o = (st_q[3] == EMPTY) | rdy[3];
      default:   ready_o = 1'b0;
    endcase
  end

  always_comb begin
    acc = '0;
    dlv = '0;
    for (int n = 0; n < 4; n++) begin
      st_d[n]  = st_q[n];
      dat_d[n] = dat_q[n];
      dlv[n]   = (st_q[n] == FULL) & rdy[n];
      acc[n]   = valid_i & ready_o & sel_oh[n];
      if (acc[n]) begin
        st_d[n]  = FULL;
        dat_d[n] = data_i;
      end else if (dlv[n]) begin
        st_d[n]  = EMPTY;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q
          + CNT_W'(dlv[0])
          + CNT_W'(dlv[1])
          + CNT_W'(dlv[2])
          + CNT_W'(dlv[3]);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int n = 0; n < 4; n++) begin
        st_q[n]  <= EMPTY;
        dat_q[n] <= '0;
      end
      cnt_q <= '0;
    end else begin
      for (int n = 0; n < 4; n++) begin
        st_q[n]  <= st_d[n];
        dat_q[n] <= dat_d[n];
      end
      cnt_q <= cnt_d;
    end
  end

  assign valid1_o   = (st_q[0] == FULL);
  assign valid2_o   = (st_q[1] == FULL);
  assign valid3_o   = (st_q[2] == FULL);
  assign valid4_o   = (st_q[3] == FULL);
  assign data1_o    = dat_q[0];
  assign data2_o    = dat_q[1];
  assign data3_o    = dat_q[2];
  assign data4_o    = dat_q[3];
  assign beat_cnt_o = cnt_q;

endmodule

// File: tb/tb_resp_demux_4.sv
// Bench for resp_demux_4: directed scenarios plus random traffic
// checked against a lane-occupancy reference model.
module tb_resp_demux_4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] data = '0;
  logic [1:0]  sel = '0;
  logic        valid = 1'b0;
  logic        ready;
  logic [3:0]  rdy = '0;
  logic [31:0] dq [4];
  logic        vq [4];
  logic [15:0] cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: what each lane holds and how many beats left.
  bit          m_full [4];
  logic [31:0] m_data [4];
  int          m_cnt;

  always #5 clk = ~clk;

  resp_demux_4 dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .data_i    (data),
    .select_i  (sel),
    .valid_i   (valid),
    .ready_o   (ready),
    .data1_o   (dq[0]),
    .data2_o   (dq[1]),
    .data3_o   (dq[2]),
    .data4_o   (dq[3]),
    .valid1_o  (vq[0]),
    .valid2_o  (vq[1]),
    .valid3_o  (vq[2]),
    .valid4_o  (vq[3]),
    .ready1_i  (rdy[0]),
    .ready2_i  (rdy[1]),
    .ready3_i  (rdy[2]),
    .ready4_i  (rdy[3]),
    .beat_cnt_o(cnt)
  );

  function automatic bit m_ready();
    return !m_full[sel] || rdy[sel];
  endfunction

  task automatic m_reset();
    for (int n = 0; n < 4; n++) begin
      m_full[n] = 0;
      m_data[n] = '0;
    end
    m_cnt = 0;
  endtask

  // Advance one clock; inputs are stable here, model follows the edge.
  task automatic tick();
    bit acc;
    int left;
    acc  = valid && m_ready();
    left = 0;
    for (int n = 0; n < 4; n++)
      if (m_full[n] && rdy[n]) left++;
    @(posedge clk);
    m_cnt = (m_cnt + left) % 65536;
    for (int n = 0; n < 4; n++) begin
      if (acc && sel == n[1:0]) begin
        m_full[n] = 1;
        m_data[n] = data;
      end else if (m_full[n] && rdy[n]) begin
        m_full[n] = 0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    valid = 1'b0;
    rdy   = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_reset();
    for (int n = 0; n < 4; n++) begin
      n_cmp++;
      if (vq[n] !== 1'b0 || dq[n] !== 32'h0) begin
        n_bad++;
        $display("FAIL reset_lane%0d valid=%b data=%h want 0/0", n + 1, vq[n], dq[n]);
      end
    end
    n_cmp++;
    if (cnt !== 16'h0) begin
      n_bad++;
      $display("FAIL reset_cnt got %h want 0000", cnt);
    end
    for (int s = 0; s < 4; s++) begin
      sel = s[1:0];
      #1;
      n_cmp++;
      if (ready !== 1'b1) begin
        n_bad++;
        $display("FAIL reset_ready sel=%0d got %b want 1", s, ready);
      end
    end
  endtask

  task automatic test_single_beat();
    rdy   = 4'b0100;
    data  = 32'hDEADBEEF;
    sel   = 2'b10;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    n_cmp++;
    if (vq[2] !== 1'b1 || dq[2] !== 32'hDEADBEEF) begin
      n_bad++;
      $display("FAIL single_lat valid3=%b data3=%h want 1/deadbeef", vq[2], dq[2]);
    end
    tick();
    n_cmp++;
    if (vq[2] !== 1'b0 || cnt !== 16'h1) begin
      n_bad++;
      $display("FAIL single_drain valid3=%b cnt=%h want 0/0001", vq[2], cnt);
    end
  endtask

  task automatic test_stall_isolation();
    logic [31:0] exp2;
    rdy   = 4'b0010;
    sel   = 2'b00;
    data  = 32'h1;
    valid = 1'b1;
    tick();
    data = 32'h2;
    #1;
    n_cmp++;
    if (ready !== 1'b0) begin
      n_bad++;
      $display("FAIL stall_ready got %b want 0", ready);
    end
    tick();
    n_cmp++;
    if (vq[0] !== 1'b1 || dq[0] !== 32'h1) begin
      n_bad++;
      $display("FAIL stall_hold valid1=%b data1=%h want 1/00000001", vq[0], dq[0]);
    end
    sel = 2'b01;
    for (int k = 0; k < 4; k++) begin
      exp2 = 32'hA + k;
      data = exp2;
      #1;
      n_cmp++;
      if (ready !== 1'b1) begin
        n_bad++;
        $display("FAIL flow_ready beat=%0d got %b want 1", k, ready);
      end
      tick();
      n_cmp++;
      if (vq[1] !== 1'b1 || dq[1] !== exp2 || dq[0] !== 32'h1) begin
        n_bad++;
        $display("FAIL flow_lane2 beat=%0d data2=%h data1=%h want %h/00000001",
                 k, dq[1], dq[0], exp2);
      end
    end
    valid = 1'b0;
    rdy   = 4'b0011;
    tick();
    n_cmp++;
    if (vq[0] !== 1'b0 || vq[1] !== 1'b0 || cnt !== m_cnt[15:0]) begin
      n_bad++;
      $display("FAIL stall_drain v1=%b v2=%b cnt=%h want 0/0/%h",
               vq[0], vq[1], cnt, m_cnt[15:0]);
    end
  endtask

  task automatic test_drain_fill();
    int c0;
    rdy   = 4'b0000;
    sel   = 2'b11;
    data  = 32'h5;
    valid = 1'b1;
    tick();
    c0    = m_cnt;
    rdy   = 4'b1000;
    data  = 32'h6;
    #1;
    n_cmp++;
    if (ready !== 1'b1) begin
      n_bad++;
      $display("FAIL fill_ready got %b want 1", ready);
    end
    tick();
    valid = 1'b0;
    n_cmp++;
    if (vq[3] !== 1'b1 || dq[3] !== 32'h6 || cnt !== 16'((c0 + 1) % 65536)) begin
      n_bad++;
      $display("FAIL drain_fill valid4=%b data4=%h cnt=%h want 1/00000006/%h",
               vq[3], dq[3], cnt, 16'((c0 + 1) % 65536));
    end
    tick();
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      rdy   = 4'($urandom);
      sel   = 2'($urandom);
      data  = $urandom;
      valid = ($urandom_range(3, 0) != 0);
      #1;
      n_cmp++;
      if (ready !== m_ready()) begin
        n_bad++;
        $display("FAIL rand_ready cyc=%0d got %b want %b", k, ready, m_ready());
      end
      tick();
      for (int n = 0; n < 4; n++) begin
        n_cmp++;
        if (vq[n] !== m_full[n] || (m_full[n] && dq[n] !== m_data[n])) begin
          n_bad++;
          $display("FAIL rand_lane%0d cyc=%0d valid=%b data=%h want %b/%h",
                   n + 1, k, vq[n], dq[n], m_full[n], m_data[n]);
        end
      end
      n_cmp++;
      if (cnt !== m_cnt[15:0]) begin
        n_bad++;
        $display("FAIL rand_cnt cyc=%0d got %h want %h", k, cnt, m_cnt[15:0]);
      end
    end
    valid = 1'b0;
    rdy   = 4'hF;
    tick();
  endtask

  task automatic test_wrap();
    rdy   = 4'b0000;
    valid = 1'b1;
    for (int s = 0; s < 3; s++) begin
      sel  = s[1:0];
      data = 32'h100 + s;
      tick();
    end
    rdy = 4'b1000;
    sel = 2'b11;
    while (m_cnt + int'(m_full[3]) < 16'hFFFE) begin
      data = $urandom;
      tick();
    end
    valid = 1'b0;
    for (int k = 0; k < 4 && m_full[3]; k++) tick();
    n_cmp++;
    if (cnt !== 16'hFFFE) begin
      n_bad++;
      $display("FAIL wrap_preload got %h want fffe", cnt);
    end
    rdy = 4'b0111;
    tick();
    n_cmp++;
    if (cnt !== 16'h0001) begin
      n_bad++;
      $display("FAIL wrap_cnt got %h want 0001", cnt);
    end
  endtask

  task automatic test_reset_mid();
    rdy   = 4'b0000;
    valid = 1'b1;
    for (int s = 0; s < 4; s++) begin
      sel  = s[1:0];
      data = 32'hC0 + s;
      tick();
    end
    valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    m_reset();
    for (int n = 0; n < 4; n++) begin
      n_cmp++;
      if (vq[n] !== 1'b0 || dq[n] !== 32'h0) begin
        n_bad++;
        $display("FAIL midreset_lane%0d valid=%b data=%h want 0/0", n + 1, vq[n], dq[n]);
      end
    end
    n_cmp++;
    if (cnt !== 16'h0) begin
      n_bad++;
      $display("FAIL midreset_cnt got %h want 0000", cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (vq[0] !== 1'b0 || vq[3] !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset_replay v1=%b v4=%b want 0/0", vq[0], vq[3]);
    end
    test_single_beat();
  endtask

  initial begin
    m_reset();
    test_reset();
    test_single_beat();
    test_stall_isolation();
    test_drain_fill();
    test_random();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
